fp_mul_seq: RTL and testbench

Sequential IEEE-754 single-precision multiplier controller. It time-shares one `adder_24bit` for a 24-iteration shift-and-add mantissa product and one `adder_10bit` for the exponent path (sum, bias removal, normalisation increment), behind a start/busy/done handshake. It is the multiply engine the power unit iterates on. It trades latency (fixed 27 cycles) for area, since only two ripple adders are instantiated.

---
 rtl/fp_pkg.sv | 18 +
 rtl/adder_10bit.sv | 13 +
 rtl/adder_24bit.sv | 15 +
 rtl/fp_mul_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared state encoding and constants for the sequential FP multiplier
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXP1 = 3'd1,
        EXP2 = 3'd2,
        MUL  = 3'd3,
        NORM = 3'd4,
        DONE = 3'd5
    } state_t;

    // -127 in 10-bit two's complement, added to remove the doubled bias
    localparam logic [9:0]  BIAS_NEG = 10'h381;
    localparam int          MUL_ITER = 24;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

endpackage

// File: rtl/adder_10bit.sv
// rtl/adder_10bit.sv - 10-bit combinational adder, wraps modulo 2^10
// Ports:
//   a, b  in  10  addends (two's complement)
//   sum   out 10  a + b modulo 2^10
module adder_10bit (
    input  logic [9:0] a,
    input  logic [9:0] b,
    output logic [9:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_24bit.sv
// rtl/adder_24bit.sv - 24-bit combinational adder with carry out
// Ports:
//   a, b  in  24  addends
//   sum   out 24  a + b modulo 2^24
//   cout  out 1   carry out of bit 23
module adder_24bit (
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [23:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential IEEE-754 single multiplier, fixed 27-cycle latency
// Ports:
//   clk     in  1   clock, rising edge
//   rst     in  1   synchronous active-high reset
//   start   in  1   request, sampled only in IDLE
//   a, b    in  32  operands, sampled with start
//   busy    out 1   high in every state except IDLE
//   done    out 1   one-cycle pulse when result updates
//   result  out 32  product, held until the next done
module fp_mul_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    state_t      state_q,  state_d;
    logic        sign_q,   sign_d;
    logic [7:0]  ea_q,     ea_d;
    logic [7:0]  eb_q,     eb_d;
    logic [23:0] ma_q,     ma_d;
    logic [23:0] mb_q,     mb_d;
    logic        zf_q,     zf_d;
    logic        nf_q,     nf_d;
    logic [47:0] p_q,      p_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [9:0]  e_q,      e_d;
    logic [31:0] result_q, result_d;
    logic        done_q,   done_d;

    logic [23:0] add24_sum;
    logic        add24_cout;
    logic [9:0]  add10_a;
    logic [9:0]  add10_b;
    logic [9:0]  add10_sum;

    adder_24bit u_add24 (
        .a    (p_q[47:24]),
        .b    (ma_q),
        .sum  (add24_sum),
        .cout (add24_cout)
    );

    adder_10bit u_add10 (
        .a   (add10_a),
        .b   (add10_b),
        .sum (add10_sum)
    );

    // Exponent adder operands are selected by state: sum, bias removal,
    // then the optional normalisation increment.
    always_comb begin
        add10_a = 10'h000;
        add10_b = 10'h000;
        unique case (state_q)
            EXP1: begin
                add10_a = {2'b00, ea_q};
                add10_b = {2'b00, eb_q};
            end
            EXP2: begin
                add10_a = e_q;
                add10_b = BIAS_NEG;
            end
            NORM: begin
                add10_a = e_q;
                add10_b = 10'h001;
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [22:0] frac;
        logic [9:0]  e_n;

        state_d  = state_q;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        e_d      = e_q;
        result_d = result_q;
        done_d   = 1'b0;
        frac     = 23'h0;
        e_n      = e_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = a[31] ^ b[31];
                    ea_d    = a[30:23];
                    eb_d    = b[30:23];
                    ma_d    = {1'b1, a[22:0]};
                    mb_d    = {1'b1, b[22:0]};
                    // Denormals are flushed to zero.
                    zf_d    = (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
                    nf_d    = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
                    p_d     = 48'h0;
                    cnt_d   = 5'd0;
                    state_d = EXP1;
                end
            end
            EXP1: begin
                e_d     = add10_sum;
                state_d = EXP2;
            end
            EXP2: begin
                e_d     = add10_sum;
                state_d = MUL;
            end
            MUL: begin
                // Shift-and-add: the partial sum enters at the top while the
                // consumed multiplier bit falls off the bottom.
                if (mb_q[0]) begin
                    p_d = 48'({add24_cout, add24_sum, p_q[23:0]} >> 1);
                end else begin
                    p_d = p_q >> 1;
                end
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MUL_ITER - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (p_q[47]) begin
                    frac = p_q[46:24];
                    e_n  = add10_sum;
                end else begin
                    frac = p_q[45:23];
                    e_n  = e_q;
                end
                e_d = e_n;
                if (zf_q && nf_q) begin
                    result_d = QNAN;
                end else if (nf_q) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                end else if (zf_q) begin
                    result_d = {sign_q, 31'h0};
                end else if (e_n[9] || (e_n == 10'h000)) begin
                    result_d = {sign_q, 31'h0};
                end else if (e_n >= 10'd255) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                end else begin
                    result_d = {sign_q, e_n[7:0], frac};
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            ea_q     <= 8'h0;
            eb_q     <= 8'h0;
            ma_q     <= 24'h0;
            mb_q     <= 24'h0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            p_q      <= 48'h0;
            cnt_q    <= 5'd0;
            e_q      <= 10'h0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            e_q      <= e_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - scoreboard bench for fp_mul_seq
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    fp_mul_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
    } exp_t;

    exp_t q[$];
    exp_t ex;
    int   free_at = 0;
    logic prev_done = 1'b0;

    // Reference: exact integer mantissa product, truncated, with the
    // special-case priority applied on the unbounded exponent.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int          ea;
        int          eb;
        int          e;
        logic        s;
        logic [63:0] prod;
        logic [22:0] frac;
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        s  = x[31] ^ y[31];
        if ((ea == 0 || eb == 0) && (ea == 255 || eb == 255)) return 32'h7FC00000;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0) return {s, 31'h0};
        prod = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
        e = ea + eb - 127;
        if (prod[47]) begin
            e++;
            frac = prod[46:24];
        end else begin
            frac = prod[45:23];
        end
        if (e <= 0) return {s, 31'h0};
        if (e >= 255) return {s, 8'hFF, 23'h0};
        return {s, e[7:0], frac};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex8;
        int         sel;
        sel = int'($urandom_range(0, 11));
        if (sel == 0)      ex8 = 8'h00;
        else if (sel == 1) ex8 = 8'hFF;
        else if (sel == 2) ex8 = 8'(int'($urandom_range(1, 20)));
        else if (sel == 3) ex8 = 8'(int'($urandom_range(230, 254)));
        else               ex8 = 8'(int'($urandom_range(90, 165)));
        return {1'($urandom), ex8, 23'($urandom)};
    endfunction

    // Issue side: decides acceptance from its own idea of when the engine
    // is free, checks busy against it, and pushes the expected response.
    always @(negedge clk) begin
        #1;
        if (cyc >= 1) begin
            checks++;
            if (busy !== (cyc < free_at)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (cyc < free_at));
            end
        end
        if (rst) begin
            q.delete();
            free_at = cyc + 1;
        end else if (start && cyc >= free_at) begin
            q.push_back('{res: ref_mul(a, b), done_cyc: cyc + 28});
            free_at = cyc + 29;
        end
    end

    // Monitor: pops and compares whenever the DUT presents done.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_double cyc=%0d done high two cycles in a row", cyc);
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d result=%08h expected no done", cyc, result);
                end else begin
                    ex = q.pop_front();
                    checks++;
                    if (result !== ex.res) begin
                        errors++;
                        $display("FAIL result cyc=%0d got=%08h want=%08h", cyc, result, ex.res);
                    end
                    checks++;
                    if (cyc != ex.done_cyc) begin
                        errors++;
                        $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, ex.done_cyc);
                    end
                end
            end else if (q.size() > 0 && cyc >= q[0].done_cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_done cyc=%0d got=0 want=1 result_want=%08h", cyc, q[0].res);
                void'(q.pop_front());
            end
            prev_done = done;
        end
    end

    task automatic drive_op(input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #2;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (27) @(posedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy got=%b want=0", tag, busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got=%b want=0", tag, done);
        end
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL %s_result got=%08h want=00000000", tag, result);
        end
    endtask

    logic [31:0] dir_a [10];
    logic [31:0] dir_b [10];

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        dir_a = '{32'h3FC00000, 32'hC0400000, 32'h3FC00000, 32'h00000000, 32'h7F000000,
                  32'h00800000, 32'h00000000, 32'h7F800000, 32'hBF800000, 32'h3F800000};
        dir_b = '{32'h40000000, 32'h3F000000, 32'h3FC00000, 32'hC2280000, 32'h7F000000,
                  32'h00800000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check_idle_zero("reset");

        for (int i = 0; i < 10; i++) drive_op(dir_a[i], dir_b[i]);

        for (int i = 0; i < 20; i++) drive_op(rand_fp(), rand_fp());

        // start held high with operands changing every cycle
        @(posedge clk);
        #2;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = rand_fp();
            b = rand_fp();
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        repeat (60) @(posedge clk);

        // reset during MUL iteration 10, after a nonzero result is held
        drive_op(32'h40400000, 32'h40000000);
        @(posedge clk);
        #2;
        a     = 32'h3FC00000;
        b     = 32'h3FC00000;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_idle_zero("mid_mul_reset");
        repeat (35) @(posedge clk);
        drive_op(32'h3FC00000, 32'h40000000);

        // rst and start together: rst wins
        @(posedge clk);
        #2;
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'h40000000;
        b     = 32'h40000000;
        @(posedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        check_idle_zero("rst_start");

        drive_op(32'h3FC00000, 32'h40000000);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
